// File: rtl/riscv_hazard_unit.sv
// riscv_hazard_unit
// -----------------------------------------------------------------------------
// Data-hazard and control-hazard detector for a 5-stage RISC-V pipeline that
// has no forwarding network. A 3-entry scoreboard tracks the destination
// register and write-enable of the instructions in EX, MEM and WB. Any source
// operand of the ID instruction that matches a live entry stalls ID (the PC
// and IF/ID are frozen and a bubble is injected into ID/EX). A taken branch in
// EX flushes IF/ID and also injects a bubble. A flush overrides a stall.
//
// Ports
//   clk             : clock, all state updates on its rising edge
//   reset           : synchronous, active-high reset
//   id_valid_in     : IF/ID holds a real instruction
//   id_rs1_in       : rs1 index of the ID instruction
//   id_rs2_in       : rs2 index of the ID instruction
//   id_rs1_used_in  : ID instruction reads rs1
//   id_rs2_used_in  : ID instruction reads rs2
//   id_rd_in        : rd index of the ID instruction
//   id_regwen_in    : ID instruction writes rd
//   branch_taken_in : EX-stage branch/jump redirects the PC this cycle
//   pipe_en_out     : enable for PC and IF/ID (0 freezes them)
//   bubble_out      : forces the control bits entering ID/EX to NOP
//   flush_out       : clears IF/ID to invalid
//   stall_cnt_out   : saturating count of cycles with pipe_en_out = 0
//   flush_cnt_out   : saturating count of cycles with flush_out = 1
// -----------------------------------------------------------------------------
module riscv_hazard_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid_in,
  input  logic [4:0]           id_rs1_in,
  input  logic [4:0]           id_rs2_in,
  input  logic                 id_rs1_used_in,
  input  logic                 id_rs2_used_in,
  input  logic [4:0]           id_rd_in,
  input  logic                 id_regwen_in,
  input  logic                 branch_taken_in,
  output logic                 pipe_en_out,
  output logic                 bubble_out,
  output logic                 flush_out,
  output logic [CNT_WIDTH-1:0] stall_cnt_out,
  output logic [CNT_WIDTH-1:0] flush_cnt_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Scoreboard: one {rd, wen} entry per downstream stage.
  logic [4:0]           ex_rd_r;
  logic                 ex_wen_r;
  logic [4:0]           mem_rd_r;
  logic                 mem_wen_r;
  logic [4:0]           wb_rd_r;
  logic                 wb_wen_r;
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] flush_cnt_r;

  logic                 rs1_hit_s;
  logic                 rs2_hit_s;
  logic                 hazard_s;
  logic                 pipe_en_s;
  logic                 bubble_s;
  logic                 flush_s;
  logic [4:0]           new_rd_s;
  logic                 new_wen_s;

  // A used, nonzero source collides with one live scoreboard entry.
  // x0 is hardwired to zero, so it can never be a real dependency.
  function automatic logic src_hit(
    input logic       used,
    input logic [4:0] idx,
    input logic [4:0] rd,
    input logic       wen
  );
    return used && (idx != 5'd0) && wen && (idx == rd);
  endfunction

  // Hazard detection, stall/flush/bubble decisions and the next EX entry.
  always_comb begin
    rs1_hit_s = src_hit(id_rs1_used_in, id_rs1_in, ex_rd_r,  ex_wen_r)  |
                src_hit(id_rs1_used_in, id_rs1_in, mem_rd_r, mem_wen_r) |
                src_hit(id_rs1_used_in, id_rs1_in, wb_rd_r,  wb_wen_r);
    rs2_hit_s = src_hit(id_rs2_used_in, id_rs2_in, ex_rd_r,  ex_wen_r)  |
                src_hit(id_rs2_used_in, id_rs2_in, mem_rd_r, mem_wen_r) |
                src_hit(id_rs2_used_in, id_rs2_in, wb_rd_r,  wb_wen_r);
    hazard_s  = id_valid_in & (rs1_hit_s | rs2_hit_s);

    // A taken branch discards the held ID instruction, so the front end must
    // keep moving to fetch the target: flush wins over stall.
    flush_s   = branch_taken_in;
    pipe_en_s = ~(hazard_s & ~branch_taken_in);
    bubble_s  = hazard_s | branch_taken_in;

    // Branch reaches the scoreboard only through the bubble decision.
    if (bubble_s) begin
      new_rd_s  = 5'd0;
      new_wen_s = 1'b0;
    end else begin
      new_rd_s  = id_rd_in;
      new_wen_s = id_regwen_in & id_valid_in;
    end
  end

  // Scoreboard shift register, EX -> MEM -> WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd_r   <= 5'd0;
      ex_wen_r  <= 1'b0;
      mem_rd_r  <= 5'd0;
      mem_wen_r <= 1'b0;
      wb_rd_r   <= 5'd0;
      wb_wen_r  <= 1'b0;
    end else begin
      wb_rd_r   <= mem_rd_r;
      wb_wen_r  <= mem_wen_r;
      mem_rd_r  <= ex_rd_r;
      mem_wen_r <= ex_wen_r;
      ex_rd_r   <= new_rd_s;
      ex_wen_r  <= new_wen_s;
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
      flush_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (!pipe_en_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign pipe_en_out   = pipe_en_s;
  assign bubble_out    = bubble_s;
  assign flush_out     = flush_s;
  assign stall_cnt_out = stall_cnt_r;
  assign flush_cnt_out = flush_cnt_r;

endmodule

// File: doc/riscv_hazard_unit.md
RISCV_HAZARD_UNIT -- requirements
Module: riscv_hazard_unit

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16: width of the stall and flush event counters.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port id_valid_in, input, 1: the IF/ID register holds a real instruction.
REQ-005 The block SHALL have ports id_rs1_in and id_rs2_in, input, 5 each: source register indices of the ID instruction.
REQ-006 The block SHALL have ports id_rs1_used_in and id_rs2_used_in, input, 1 each: the ID instruction reads rs1 / rs2.
REQ-007 The block SHALL have port id_rd_in, input, 5: destination index of the ID instruction.
REQ-008 The block SHALL have port id_regwen_in, input, 1: the ID instruction writes rd (controller RegWEn).
REQ-009 The block SHALL have port branch_taken_in, input, 1: an EX-stage branch or jump redirects the PC this cycle (pcsel).
REQ-010 The block SHALL have port pipe_en_out, output, 1: enable for the PC and IF/ID registers; 0 freezes them.
REQ-011 The block SHALL have port bubble_out, output, 1: forces all control bits entering ID/EX (regwen, memrw, wbsel, alusel, asel, bsel) to NOP.
REQ-012 The block SHALL have port flush_out, output, 1: clears IF/ID to invalid.
REQ-013 The block SHALL have ports stall_cnt_out and flush_cnt_out, output, CNT_WIDTH each: saturating event counts.

Function
REQ-014 The block SHALL keep a 3-entry scoreboard {rd[4:0], wen} for the EX, MEM and WB stages; there is no forwarding path, so all three entries are hazard sources.
REQ-015 Each cycle, the scoreboard SHALL shift: WB<=MEM, MEM<=EX, EX<=new entry.
REQ-016 The new EX entry SHALL be {id_rd_in, id_regwen_in & id_valid_in} when bubble_out=0, and {0, 0} when bubble_out=1.
REQ-017 The block SHALL declare a source match when the source is used, its index is nonzero, and it equals the rd of any scoreboard entry with wen=1.
REQ-018 The block SHALL declare hazard = id_valid_in & (rs1 match | rs2 match), evaluated combinationally from current inputs and registered scoreboard.
REQ-019 Register x0 SHALL never produce a hazard, regardless of wen.
REQ-020 The block SHALL drive flush_out = branch_taken_in.
REQ-021 The block SHALL drive pipe_en_out = ~(hazard & ~branch_taken_in); flush has priority over stall.
REQ-022 The block SHALL drive bubble_out = hazard | branch_taken_in.
REQ-023 A dependent instruction at distance 1 (immediately following its producer) SHALL see exactly 3 stall cycles; distance 2 SHALL see 2, distance 3 SHALL see 1, and distance >=4 SHALL see 0.
REQ-024 During a stall, the ID instruction SHALL be held, and hazard SHALL re-evaluate each cycle as bubbles shift the producer out.
REQ-025 When branch_taken_in and hazard are both 1, pipe_en_out SHALL be 1, flush_out SHALL be 1, bubble_out SHALL be 1, and the held ID instruction SHALL be discarded.
REQ-026 stall_cnt_out SHALL increment on every cycle with pipe_en_out=0, and flush_cnt_out SHALL increment on every cycle with flush_out=1.
REQ-027 Both counters SHALL saturate at 2^CNT_WIDTH-1 and SHALL never wrap.
REQ-028 The outputs SHALL contain no combinational path from branch_taken_in to the scoreboard other than through bubble_out.

Reset
REQ-029 While reset=1 at a clock edge, all scoreboard entries SHALL be set to {0, 0} and both counters SHALL be set to 0.
REQ-030 With reset asserted and id_valid_in=0, pipe_en_out SHALL be 1, bubble_out SHALL be 0 and flush_out SHALL be 0.
REQ-031 A reset arriving mid-stall SHALL clear the scoreboard so that the stall ends in the cycle after reset.

Verification
REQ-032 The bench SHALL cover: addi x5 then add x6,x5,x1 back-to-back -> pipe_en_out=0 for exactly 3 cycles, 3 bubbles, stall_cnt_out=3.
REQ-033 The bench SHALL cover: producer x7, one independent instruction, then consumer of x7 -> 2 stall cycles; with two independent instructions between -> 1 stall cycle; with three between -> 0.
REQ-034 The bench SHALL cover: producer rd=x0 with wen=1, then consumer rs1=x0 -> no stall, and a producer with wen=0 -> no stall.
REQ-035 The bench SHALL cover: hazard present and branch_taken_in=1 in the same cycle -> pipe_en_out=1, flush_out=1, bubble_out=1, flush_cnt_out=1, stall_cnt_out unchanged.
REQ-036 The bench SHALL cover: reset asserted on the 2nd stall cycle -> the next cycle has pipe_en_out=1 and both counters read 0.
REQ-037 The bench SHALL cover: CNT_WIDTH=4 with 20 consecutive stall cycles -> stall_cnt_out holds at 15.
